// File: rtl/cordic_vector.sv
// cordic_vector: CORDIC vectoring-mode unit computing atan2(y_in, x_in) and |(x_in, y_in)|.
// Inputs are Q2.20, the angle is Q3.20 and the magnitude is unsigned Q5.20.
// Build option: define CORDIC_VECTOR_GAIN_COMP_EN to scale mag_out by K = 0.607252
// (removing the CORDIC gain). This adds the COMP state and one cycle of latency.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; x_in/y_in captured on the accepting edge
// PRE   | quadrant pre-rotation into the right half-plane
// ITER  | 16 micro-rotations (i = 0..15) driving y toward zero
// COMP  | gain compensation of x (only with CORDIC_VECTOR_GAIN_COMP_EN)
// DONE  | results valid in angle_out/mag_out, done pulses for one cycle
module cordic_vector (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [21:0] x_in,
   input  logic [21:0] y_in,
   output logic        busy,
   output logic        done,
   output logic [22:0] angle_out,
   output logic [24:0] mag_out
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PRE  = 3'd1,
      ITER = 3'd2,
      COMP = 3'd3,
      DONE = 3'd4
   } state_t;

   // pi/2 in Q3.20
   localparam logic signed [22:0] HALF_PI = 23'sd1647099;

   state_t state;
   state_t state_nxt;

   logic signed [24:0] x_r;
   logic signed [24:0] y_r;
   logic signed [22:0] z_r;
   logic [3:0]         iter_r;
   // both inputs zero: the iterations would still accumulate angle, so results are forced
   logic               zero_r;

   logic signed [24:0] x_step;
   logic signed [24:0] y_step;
   logic signed [22:0] z_step;
   logic signed [22:0] e_i;

   // atan(2^-i) in Q2.20
   function automatic logic signed [22:0] atan_lut(input logic [3:0] idx);
      logic signed [22:0] v;
      case (idx)
         4'd0:    v = 23'sd823549;
         4'd1:    v = 23'sd486170;
         4'd2:    v = 23'sd256879;
         4'd3:    v = 23'sd130396;
         4'd4:    v = 23'sd65451;
         4'd5:    v = 23'sd32757;
         4'd6:    v = 23'sd16383;
         4'd7:    v = 23'sd8192;
         4'd8:    v = 23'sd4096;
         4'd9:    v = 23'sd2048;
         4'd10:   v = 23'sd1024;
         4'd11:   v = 23'sd512;
         4'd12:   v = 23'sd256;
         4'd13:   v = 23'sd128;
         4'd14:   v = 23'sd64;
         default: v = 23'sd32;
      endcase
      return v;
   endfunction

   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state and Moore outputs; busy spans PRE through COMP, done is the DONE cycle
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = PRE;
            end
         end
         PRE: begin
            busy      = 1'b1;
            state_nxt = ITER;
         end
         ITER: begin
            busy = 1'b1;
            if (iter_r == 4'd15) begin
`ifdef CORDIC_VECTOR_GAIN_COMP_EN
               state_nxt = COMP;
`else
               state_nxt = DONE;
`endif
            end
         end
         COMP: begin
            busy      = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // one micro-rotation from the current x, y, z; direction chosen by the sign of y
   always_comb begin
      e_i = atan_lut(iter_r);
      if (!y_r[24]) begin
         x_step = x_r + (y_r >>> iter_r);
         y_step = y_r - (x_r >>> iter_r);
         z_step = z_r + e_i;
      end else begin
         x_step = x_r - (y_r >>> iter_r);
         y_step = y_r + (x_r >>> iter_r);
         z_step = z_r - e_i;
      end
   end

`ifdef CORDIC_VECTOR_GAIN_COMP_EN
   // x is non-negative after vectoring, so an unsigned multiply by K (Q0.20) is exact enough
   logic [44:0] comp_prod;
   logic [24:0] mag_comp;

   // gain compensation product x * 636750 >> 20
   always_comb begin
      comp_prod = {20'd0, x_r} * 45'd636750;
      mag_comp  = 25'(comp_prod >> 20);
   end
`endif

   // working registers: capture, pre-rotation, micro-rotations, optional compensation
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x_r    <= '0;
         y_r    <= '0;
         z_r    <= '0;
         iter_r <= '0;
         zero_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  x_r    <= {{3{x_in[21]}}, x_in};
                  y_r    <= {{3{y_in[21]}}, y_in};
                  z_r    <= '0;
                  iter_r <= '0;
                  zero_r <= (x_in == 22'd0) && (y_in == 22'd0);
               end
            end
            PRE: begin
               iter_r <= '0;
               if (!x_r[24]) begin
                  z_r <= '0;
               end else if (!y_r[24]) begin
                  x_r <= y_r;
                  y_r <= -x_r;
                  z_r <= HALF_PI;
               end else begin
                  x_r <= -y_r;
                  y_r <= x_r;
                  z_r <= -HALF_PI;
               end
            end
            ITER: begin
               x_r    <= x_step;
               y_r    <= y_step;
               z_r    <= z_step;
               iter_r <= iter_r + 4'd1;
            end
`ifdef CORDIC_VECTOR_GAIN_COMP_EN
            COMP: begin
               x_r <= signed'(mag_comp);
            end
`endif
            default: begin
            end
         endcase
      end
   end

   // result registers load on the edge entering DONE and hold until the next completion
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         angle_out <= '0;
         mag_out   <= '0;
      end else begin
`ifdef CORDIC_VECTOR_GAIN_COMP_EN
         if (state == COMP) begin
            angle_out <= zero_r ? 23'd0 : z_r;
            mag_out   <= zero_r ? 25'd0 : mag_comp;
         end
`else
         if ((state == ITER) && (iter_r == 4'd15)) begin
            angle_out <= zero_r ? 23'd0 : z_step;
            mag_out   <= zero_r ? 25'd0 : x_step;
         end
`endif
      end
   end

endmodule

// File: tb/tb_cordic_vector.sv
// tb_cordic_vector: self-checking bench for cordic_vector against a real-arithmetic
// atan2/hypot model. Honours CORDIC_VECTOR_GAIN_COMP_EN for latency and gain.
module tb_cordic_vector;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [21:0] x_in;
   logic [21:0] y_in;
   logic        busy;
   logic        done;
   logic [22:0] angle_out;
   logic [24:0] mag_out;

   int checks   = 0;
   int failures = 0;

`ifdef CORDIC_VECTOR_GAIN_COMP_EN
   localparam int LAT      = 18;
   localparam bit GAIN_CMP = 1'b1;
`else
   localparam int LAT      = 17;
   localparam bit GAIN_CMP = 1'b0;
`endif

   localparam real SCALE  = 1048576.0;
   localparam real PI_LSB = 3.14159265358979 * 1048576.0;

   localparam logic [21:0] DIR_X [9] = '{22'h100000, 22'h100000, 22'h300000, 22'h300000,
                                        22'h000000, 22'h000000, 22'h200000, 22'h200000,
                                        22'h1FFFFF};
   localparam logic [21:0] DIR_Y [9] = '{22'h000000, 22'h100000, 22'h000000, 22'h3FFFFF,
                                        22'h300000, 22'h000000, 22'h000000, 22'h200000,
                                        22'h1FFFFF};

   cordic_vector dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .x_in      (x_in),
      .y_in      (y_in),
      .busy      (busy),
      .done      (done),
      .angle_out (angle_out),
      .mag_out   (mag_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: ideal atan2 in Q3.20 LSBs
   function automatic real model_angle(input int xi, input int yi);
      if (xi == 0 && yi == 0) return 0.0;
      return $atan2(real'(yi), real'(xi)) * SCALE;
   endfunction

   // reference model: true magnitude, times the 16-stage CORDIC gain when uncompensated
   function automatic real model_mag(input int xi, input int yi);
      real m;
      real g;
      m = $sqrt(real'(xi) * real'(xi) + real'(yi) * real'(yi));
      g = 1.0;
      for (int k = 0; k < 16; k++) g = g * $sqrt(1.0 + $pow(2.0, -2.0 * k));
      return GAIN_CMP ? m : m * g;
   endfunction

   function automatic real wrap_diff(input real d);
      real r;
      r = d;
      if (r > PI_LSB) r = r - 2.0 * PI_LSB;
      if (r < -PI_LSB) r = r + 2.0 * PI_LSB;
      return r;
   endfunction

   // drives one operation from a post-edge point and collects what the DUT produced
   task automatic do_op(input logic [21:0] xv, input logic [21:0] yv, output int lat,
                        output bit busy_ok, output int ang, output int mag, output bit after_ok);
      int n;
      x_in  = xv;
      y_in  = yv;
      start = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
      busy_ok = (busy === 1'b1);
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
         if (done !== 1'b1 && busy !== 1'b1) busy_ok = 1'b0;
      end
      lat = (done === 1'b1) ? n : -1;
      if (busy !== 1'b0) busy_ok = 1'b0;
      ang = $signed(angle_out);
      mag = int'(mag_out);
      @(posedge clk); #1;
      after_ok = (done === 1'b0) && (busy === 1'b0) &&
                 (int'($signed(angle_out)) == ang) && (int'(mag_out) == mag);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      start   = 1'b0;
      x_in    = '0;
      y_in    = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (angle_out !== 23'd0) begin failures++; $display("FAIL reset_angle got=%0d exp=0", angle_out); end
      checks++; if (mag_out !== 25'd0) begin failures++; $display("FAIL reset_mag got=%0d exp=0", mag_out); end
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_no_start busy got=%b exp=0", busy); end
   endtask

   task automatic test_directed();
      int lat, ang, mag, xi, yi;
      bit bok, aok, zero;
      real ea, em, d;
      for (int t = 0; t < 9; t++) begin
         do_op(DIR_X[t], DIR_Y[t], lat, bok, ang, mag, aok);
         xi   = $signed(DIR_X[t]);
         yi   = $signed(DIR_Y[t]);
         zero = (xi == 0) && (yi == 0);
         ea   = model_angle(xi, yi);
         em   = model_mag(xi, yi);
         d    = wrap_diff(real'(ang) - ea);
         checks++; if (lat != LAT) begin failures++; $display("FAIL dir%0d latency got=%0d exp=%0d", t, lat, LAT); end
         checks++; if (!bok) begin failures++; $display("FAIL dir%0d busy_window got=0 exp=1", t); end
         checks++;
         if (zero ? (ang != 0) : (d > 64.0 || d < -64.0)) begin
            failures++; $display("FAIL dir%0d angle got=%0d exp=%0.1f", t, ang, ea);
         end
         checks++;
         if (zero ? (mag != 0) : (real'(mag) - em > 128.0 || em - real'(mag) > 128.0)) begin
            failures++; $display("FAIL dir%0d mag got=%0d exp=%0.1f", t, mag, em);
         end
         checks++; if (!aok) begin failures++; $display("FAIL dir%0d single_pulse_hold got=0 exp=1", t); end
      end
   endtask

   task automatic test_back_to_back();
      int lat1, lat2, ang, mag;
      bit bok, aok;
      real ea;
      do_op(22'h0A0000, 22'h060000, lat1, bok, ang, mag, aok);
      do_op(22'h060000, 22'h3A0000, lat2, bok, ang, mag, aok);
      ea = model_angle(32'sh060000, -32'sh060000);
      checks++; if (lat2 != LAT) begin failures++; $display("FAIL b2b latency got=%0d exp=%0d", lat2, LAT); end
      checks++;
      if (real'(ang) - ea > 64.0 || ea - real'(ang) > 64.0) begin
         failures++; $display("FAIL b2b angle got=%0d exp=%0.1f", ang, ea);
      end
   endtask

   task automatic test_random();
      int lat, ang, mag, xi, yi, guard;
      bit bok, aok;
      logic [21:0] xv, yv;
      real ea, em, d;
      for (int t = 0; t < 20; t++) begin
         guard = 0;
         do begin
            xv = 22'($urandom);
            yv = 22'($urandom);
            xi = $signed(xv);
            yi = $signed(yv);
            guard++;
         end while (xi < 786432 && xi > -786432 && yi < 786432 && yi > -786432 && guard < 100);
         if (guard >= 100) begin
            xv = 22'h100000;
            xi = 1048576;
         end
         do_op(xv, yv, lat, bok, ang, mag, aok);
         ea = model_angle(xi, yi);
         em = model_mag(xi, yi);
         d  = wrap_diff(real'(ang) - ea);
         checks++; if (lat != LAT) begin failures++; $display("FAIL rnd%0d latency got=%0d exp=%0d", t, lat, LAT); end
         checks++;
         if (d > 64.0 || d < -64.0) begin
            failures++; $display("FAIL rnd%0d angle x=%0d y=%0d got=%0d exp=%0.1f", t, xi, yi, ang, ea);
         end
         checks++;
         if (real'(mag) - em > 128.0 || em - real'(mag) > 128.0) begin
            failures++; $display("FAIL rnd%0d mag x=%0d y=%0d got=%0d exp=%0.1f", t, xi, yi, mag, em);
         end
      end
   endtask

   task automatic test_start_while_busy();
      int ndone, first, ang, mag;
      bit rejected;
      real ea, em;
      ndone    = 0;
      first    = -1;
      ang      = 0;
      mag      = 0;
      rejected = 1'b0;
      x_in  = 22'h0E0000;
      y_in  = 22'h320000;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin
            ndone++;
            if (first < 0) begin
               first = k;
               ang   = $signed(angle_out);
               mag   = int'(mag_out);
            end
         end
         if (k == LAT + 1) rejected = (busy === 1'b0);
         start = 1'b0;
         if (k == 4 || k == LAT) begin
            x_in  = 22'h300000;
            y_in  = 22'h100000;
            start = 1'b1;
         end
      end
      ea = model_angle(32'sh0E0000, -32'sh0E0000);
      em = model_mag(32'sh0E0000, -32'sh0E0000);
      checks++; if (ndone != 1) begin failures++; $display("FAIL busy_start done_count got=%0d exp=1", ndone); end
      checks++; if (first != LAT) begin failures++; $display("FAIL busy_start latency got=%0d exp=%0d", first, LAT); end
      checks++; if (!rejected) begin failures++; $display("FAIL start_in_done accepted got=1 exp=0"); end
      checks++;
      if (real'(ang) - ea > 64.0 || ea - real'(ang) > 64.0) begin
         failures++; $display("FAIL busy_start angle got=%0d exp=%0.1f", ang, ea);
      end
      checks++;
      if (real'(mag) - em > 128.0 || em - real'(mag) > 128.0) begin
         failures++; $display("FAIL busy_start mag got=%0d exp=%0.1f", mag, em);
      end
   endtask

   task automatic test_reset_mid();
      int lat, ang, mag, seen, n;
      bit bok, aok;
      real ea;
      do_op(22'h100000, 22'h080000, lat, bok, ang, mag, aok);
      x_in  = 22'h0C0000;
      y_in  = 22'h3C0000;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", done); end
      checks++; if (angle_out !== 23'd0) begin failures++; $display("FAIL midrst_angle got=%0d exp=0", angle_out); end
      checks++; if (mag_out !== 25'd0) begin failures++; $display("FAIL midrst_mag got=%0d exp=0", mag_out); end
      seen = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (done === 1'b1) seen++;
      end
      x_in    = 22'h3A0000;
      y_in    = 22'h150000;
      start   = 1'b1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL first_edge_accept busy got=%b exp=1", busy); end
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      lat = (done === 1'b1) ? n : -1;
      ang = $signed(angle_out);
      checks++; if (seen != 0) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", seen); end
      checks++; if (lat != LAT) begin failures++; $display("FAIL post_rst latency got=%0d exp=%0d", lat, LAT); end
      ea = model_angle(-32'sh060000, 32'sh150000);
      checks++;
      if (real'(ang) - ea > 64.0 || ea - real'(ang) > 64.0) begin
         failures++; $display("FAIL post_rst angle got=%0d exp=%0.1f", ang, ea);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_random();
      test_start_while_busy();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
